digit_renderer: RTL and testbench

- Pixel-pipeline stage directly upstream and downstream of the digit font ROM in the VGA clock.
- Maps the current VGA beam position to a font ROM address: digit value × glyph height + glyph row.
- Takes back the ROM's registered row word and selects the column bit, producing a latency-aligned `pix_on` for the colour mux.
- Renders six BCD digits (HH MM SS) as scaled block glyphs. Digits are latched once per frame so the display never tears.

---
 rtl/digit_render_pkg.sv | 18 +
 rtl/glyph_locator.sv | 54 +++++
 rtl/digit_renderer.sv | 86 ++++++++
 tb/tb_digit_renderer.sv | 275 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/digit_render_pkg.sv
// Shared types and helpers for the digit renderer pixel stage.
package digit_render_pkg;

  localparam int unsigned DIGIT_PITCH    = 4;
  localparam logic [3:0]  BLANK_DIGIT    = 4'hF;
  localparam int unsigned PIPE_LAT       = 3;
  localparam int unsigned DEF_NUM_DIGITS = 6;

  typedef logic [3:0] bcd_t;
  typedef bcd_t [DEF_NUM_DIGITS-1:0] digit_arr_t;

  // Font ROM row address for a glyph row; the caller truncates to its address width.
  function automatic logic [15:0] digit_addr(input bcd_t digit, input logic [15:0] row,
                                             input int unsigned font_h);
    return 16'(digit) * 16'(font_h) + row;
  endfunction

endpackage

// File: rtl/glyph_locator.sv
// Combinational beam-position to glyph lookup: hit flag, font ROM address and glyph column.
module glyph_locator
  import digit_render_pkg::*;
#(
  parameter int unsigned COORD_W     = 10,
  parameter int unsigned X0          = 64,
  parameter int unsigned Y0          = 200,
  parameter int unsigned BLOCK_SHIFT = 4,
  parameter int unsigned NUM_DIGITS  = 6,
  parameter int unsigned FONT_W      = 3,
  parameter int unsigned FONT_H      = 5,
  parameter int unsigned ADDR_W      = 6
) (
  input  logic [COORD_W-1:0]          x,
  input  logic [COORD_W-1:0]          y,
  input  logic                        active,
  input  bcd_t [NUM_DIGITS-1:0]       digits,
  output logic                        hit_c,
  output logic [ADDR_W-1:0]           addr_c,
  output logic [1:0]                  col_c
);

  localparam int unsigned PITCH_SHIFT = $clog2(DIGIT_PITCH);

  logic [COORD_W-1:0] rel_x;
  logic [COORD_W-1:0] rel_y;
  logic [COORD_W-1:0] bx;
  logic [COORD_W-1:0] by;
  logic [COORD_W-1:0] idx;
  bcd_t               sel;

  // Subtraction may wrap left/above the field; the explicit compares gate hit_c.
  always_comb begin
    rel_x = x - COORD_W'(X0);
    rel_y = y - COORD_W'(Y0);
    bx    = rel_x >> BLOCK_SHIFT;
    by    = rel_y >> BLOCK_SHIFT;
    idx   = bx >> PITCH_SHIFT;
    col_c = bx[1:0];
    sel   = BLANK_DIGIT;
    for (int i = 0; i < NUM_DIGITS; i++) begin
      if (idx == COORD_W'(i)) sel = digits[NUM_DIGITS-1-i];
    end
    hit_c  = active
           && (x >= COORD_W'(X0))
           && (y >= COORD_W'(Y0))
           && (idx < COORD_W'(NUM_DIGITS))
           && (3'(col_c) < 3'(FONT_W))
           && (by < COORD_W'(FONT_H))
           && (sel <= 4'd9);
    addr_c = ADDR_W'(digit_addr(sel, 16'(by), FONT_H));
  end

endmodule

// File: rtl/digit_renderer.sv
// Three-stage pixel pipeline around the digit font ROM: address out, row word back, pixel select.
module digit_renderer
  import digit_render_pkg::*;
#(
  parameter int unsigned COORD_W     = 10,
  parameter int unsigned X0          = 64,
  parameter int unsigned Y0          = 200,
  parameter int unsigned BLOCK_SHIFT = 4,
  parameter int unsigned NUM_DIGITS  = 6,
  parameter int unsigned FONT_W      = 3,
  parameter int unsigned FONT_H      = 5,
  parameter int unsigned ADDR_W      = 6
) (
  input  logic                      clk,
  input  logic                      reset_n,
  input  logic [COORD_W-1:0]        x,
  input  logic [COORD_W-1:0]        y,
  input  logic                      active,
  input  logic                      frame_start,
  input  logic [4*NUM_DIGITS-1:0]   digits,
  output logic [ADDR_W-1:0]         rom_addr,
  input  logic [FONT_W-1:0]         rom_data,
  output logic                      pix_on,
  output logic                      active_out
);

  bcd_t [NUM_DIGITS-1:0] dig_q;
  bcd_t [NUM_DIGITS-1:0] dig_cur_c;
  logic                  hit_c;
  logic [ADDR_W-1:0]     addr_c;
  logic [1:0]            col_c;

  logic       hit_d1, hit_d2, act_d1, act_d2;
  logic [1:0] col_d1, col_d2;
  logic [1:0]        bit_idx_c;
  logic [FONT_W-1:0] row_sh_c;

  // A frame_start edge uses the incoming digits for the pixel on that same cycle.
  assign dig_cur_c = frame_start ? digits : dig_q;

  glyph_locator #(
    .COORD_W(COORD_W), .X0(X0), .Y0(Y0), .BLOCK_SHIFT(BLOCK_SHIFT),
    .NUM_DIGITS(NUM_DIGITS), .FONT_W(FONT_W), .FONT_H(FONT_H), .ADDR_W(ADDR_W)
  ) u_locator (
    .x      (x),
    .y      (y),
    .active (active),
    .digits (dig_cur_c),
    .hit_c  (hit_c),
    .addr_c (addr_c),
    .col_c  (col_c)
  );

  // Leftmost glyph column lives in the MSB of the ROM word.
  always_comb begin
    bit_idx_c = 2'(FONT_W-1) - col_d2;
    row_sh_c  = rom_data >> bit_idx_c;
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      dig_q      <= {NUM_DIGITS{BLANK_DIGIT}};
      rom_addr   <= '0;
      hit_d1     <= 1'b0;
      hit_d2     <= 1'b0;
      act_d1     <= 1'b0;
      act_d2     <= 1'b0;
      col_d1     <= '0;
      col_d2     <= '0;
      pix_on     <= 1'b0;
      active_out <= 1'b0;
    end else begin
      if (frame_start) dig_q <= digits;
      if (hit_c) rom_addr <= addr_c;
      hit_d1     <= hit_c;
      col_d1     <= col_c;
      act_d1     <= active;
      hit_d2     <= hit_d1;
      col_d2     <= col_d1;
      act_d2     <= act_d1;
      pix_on     <= hit_d2 & row_sh_c[0];
      active_out <= act_d2;
    end
  end

endmodule

// File: tb/tb_digit_renderer.sv
// Randomised self-checking bench for digit_renderer with a behavioural font ROM and pixel model.
module tb_digit_renderer;
  import digit_render_pkg::*;

  localparam int unsigned COORD_W = 10;
  localparam int unsigned ADDR_W  = 6;
  localparam int XL = 64;
  localparam int YT = 200;

  logic               clk;
  logic               reset_n;
  logic [COORD_W-1:0] x, y;
  logic               active, frame_start;
  logic [23:0]        digits;
  logic [ADDR_W-1:0]  rom_addr;
  logic [2:0]         rom_data;
  logic               pix_on, active_out;

  logic [2:0] font [64];
  digit_arr_t lat;
  int         m_addr;
  bit         qp[$];
  bit         qa[$];
  int         total = 0;
  int         bad   = 0;

  digit_renderer #(
    .COORD_W(10), .X0(64), .Y0(200), .BLOCK_SHIFT(4), .NUM_DIGITS(6),
    .FONT_W(3), .FONT_H(5), .ADDR_W(6)
  ) dut (
    .clk(clk), .reset_n(reset_n), .x(x), .y(y), .active(active),
    .frame_start(frame_start), .digits(digits), .rom_addr(rom_addr),
    .rom_data(rom_data), .pix_on(pix_on), .active_out(active_out)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Registered font ROM: data valid one clock after the address.
  always @(posedge clk) rom_data <= font[rom_addr];

  // Glyph lookup straight from the screen geometry: 16px blocks, 4-block digit pitch, 3x5 glyphs.
  function automatic bit ref_hit(input int xx, input int yy, input bit act, input logic [23:0] d,
                                 output int addr, output int col);
    int bx, idx, row, dv;
    addr = 0;
    col  = 0;
    if (!act || xx < XL || yy < YT) return 1'b0;
    bx  = (xx - XL) / 16;
    idx = bx / 4;
    col = bx % 4;
    row = (yy - YT) / 16;
    if (idx >= 6 || col >= 3 || row >= 5) return 1'b0;
    dv = int'((d >> (4 * (5 - idx))) & 24'hF);
    if (dv > 9) return 1'b0;
    addr = dv * 5 + row;
    return 1'b1;
  endfunction

  task automatic drive(input int xx, input int yy, input bit act, input bit fs,
                       input logic [23:0] dg, output bit chk, output bit ep, output bit ea);
    int a, c;
    bit h, lit;
    logic [2:0] w;
    x = COORD_W'(xx);
    y = COORD_W'(yy);
    active = act;
    frame_start = fs;
    digits = dg;
    if (fs) lat = dg;
    h = ref_hit(xx, yy, act, lat, a, c);
    lit = 1'b0;
    if (h) begin
      m_addr = a;
      w = font[a];
      lit = w[2 - c];
    end
    qp.push_back(lit);
    qa.push_back(act);
    @(posedge clk);
    #1;
    frame_start = 1'b0;
    chk = (qp.size() == PIPE_LAT);
    ep = 1'b0;
    ea = 1'b0;
    if (chk) begin
      ep = qp.pop_front();
      ea = qa.pop_front();
    end
  endtask

  task automatic do_reset();
    reset_n = 1'b0;
    lat = {6{BLANK_DIGIT}};
    m_addr = 0;
    qp.delete();
    qa.delete();
    repeat (2) @(posedge clk);
    #1;
    reset_n = 1'b1;
    for (int i = 0; i < PIPE_LAT - 1; i++) begin
      qp.push_back(1'b0);
      qa.push_back(1'b0);
    end
  endtask

  task automatic test_reset();
    bit chk, ep, ea;
    reset_n = 1'b0;
    x = 10'd64; y = 10'd200; active = 1'b1; frame_start = 1'b0; digits = 24'h123456;
    repeat (3) @(posedge clk);
    #1;
    total++; if (rom_addr !== 6'd0) begin bad++; $display("FAIL reset_rom_addr: got %0d want 0", rom_addr); end
    total++; if (pix_on !== 1'b0) begin bad++; $display("FAIL reset_pix_on: got %b want 0", pix_on); end
    total++; if (active_out !== 1'b0) begin bad++; $display("FAIL reset_active_out: got %b want 0", active_out); end
    do_reset();
    for (int i = 0; i < 40; i++) begin
      drive($urandom_range(64, 447), $urandom_range(200, 279), 1'b1, 1'b0, 24'h123456, chk, ep, ea);
      total++; if (rom_addr !== ADDR_W'(m_addr)) begin bad++; $display("FAIL blank_addr: got %0d want %0d", rom_addr, m_addr); end
      if (chk) begin
        total++;
        if (pix_on !== ep || active_out !== ea) begin
          bad++; $display("FAIL blank_pix: got pix=%b act=%b want pix=%b act=%b", pix_on, active_out, ep, ea);
        end
      end
    end
  endtask

  task automatic test_addr_map();
    bit chk, ep, ea;
    drive(64, 200, 1'b1, 1'b1, 24'h123456, chk, ep, ea);
    total++; if (rom_addr !== 6'd5) begin bad++; $display("FAIL addr_first: got %0d want 5", rom_addr); end
    drive(416, 248, 1'b1, 1'b0, 24'h123456, chk, ep, ea);
    total++; if (rom_addr !== 6'd33) begin bad++; $display("FAIL addr_last: got %0d want 33", rom_addr); end
  endtask

  task automatic test_latency();
    bit chk, ep, ea;
    bit p[6];
    bit q[6];
    int xs[6] = '{64, 80, 96, 0, 0, 0};
    bit as[6] = '{1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0};
    for (int i = 0; i < 6; i++) begin
      drive(xs[i], 200, as[i], 1'b0, 24'h123456, chk, ep, ea);
      p[i] = pix_on;
      q[i] = active_out;
      if (chk) begin
        total++;
        if (pix_on !== ep || active_out !== ea) begin
          bad++; $display("FAIL lat_model: got pix=%b act=%b want pix=%b act=%b", pix_on, active_out, ep, ea);
        end
      end
    end
    total++; if (p[2] !== 1'b1) begin bad++; $display("FAIL lat_col0: got %b want 1", p[2]); end
    total++; if (p[3] !== 1'b0) begin bad++; $display("FAIL lat_col1: got %b want 0", p[3]); end
    total++; if (p[4] !== 1'b1) begin bad++; $display("FAIL lat_col2: got %b want 1", p[4]); end
    total++; if (p[5] !== 1'b0) begin bad++; $display("FAIL lat_idle: got %b want 0", p[5]); end
    total++; if (q[4] !== 1'b1 || q[5] !== 1'b0) begin
      bad++; $display("FAIL lat_active_out: got %b%b want 10", q[4], q[5]);
    end
  endtask

  task automatic test_off_glyph();
    bit chk, ep, ea;
    int ox[6] = '{64, 112, 63, 64, 448, 64};
    int oy[6] = '{200, 200, 200, 280, 200, 200};
    bit oa[6] = '{1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0};
    for (int i = 0; i < 9; i++) begin
      if (i < 6) drive(ox[i], oy[i], oa[i], 1'b0, 24'h123456, chk, ep, ea);
      else       drive(0, 0, 1'b0, 1'b0, 24'h123456, chk, ep, ea);
      total++; if (rom_addr !== ADDR_W'(m_addr)) begin bad++; $display("FAIL off_addr: got %0d want %0d", rom_addr, m_addr); end
      if (i == 2) begin
        total++; if (rom_addr !== 6'd5) begin bad++; $display("FAIL off_nowrap: got %0d want 5", rom_addr); end
      end
      if (chk) begin
        total++;
        if (pix_on !== ep || active_out !== ea) begin
          bad++; $display("FAIL off_pix: got pix=%b act=%b want pix=%b act=%b", pix_on, active_out, ep, ea);
        end
      end
    end
  endtask

  task automatic test_latch();
    bit chk, ep, ea;
    drive(64, 200, 1'b1, 1'b0, 24'h999999, chk, ep, ea);
    total++; if (rom_addr !== 6'd5) begin bad++; $display("FAIL latch_hold: got %0d want 5", rom_addr); end
    drive(64, 200, 1'b1, 1'b1, 24'h999999, chk, ep, ea);
    total++; if (rom_addr !== 6'd45) begin bad++; $display("FAIL latch_new: got %0d want 45", rom_addr); end
    drive(64, 200, 1'b1, 1'b1, 24'hA23456, chk, ep, ea);
    total++; if (rom_addr !== 6'd45) begin bad++; $display("FAIL latch_blank_addr: got %0d want 45", rom_addr); end
    for (int i = 0; i < 3; i++) begin
      drive(64, 200, 1'b1, 1'b0, 24'hA23456, chk, ep, ea);
      if (chk) begin
        total++;
        if (pix_on !== ep || active_out !== ea) begin
          bad++; $display("FAIL latch_pix: got pix=%b act=%b want pix=%b act=%b", pix_on, active_out, ep, ea);
        end
      end
    end
    total++; if (pix_on !== 1'b0) begin bad++; $display("FAIL latch_blank_pix: got %b want 0", pix_on); end
  endtask

  task automatic test_random();
    bit chk, ep, ea;
    logic [23:0] dg;
    dg = 24'h123456;
    for (int i = 0; i < 400; i++) begin
      if ($urandom_range(0, 7) == 0) begin
        for (int k = 0; k < 6; k++) dg[4*k +: 4] = 4'($urandom_range(0, 11));
      end
      drive($urandom_range(40, 520), $urandom_range(180, 300), $urandom_range(0, 3) != 0,
            $urandom_range(0, 15) == 0, dg, chk, ep, ea);
      total++; if (rom_addr !== ADDR_W'(m_addr)) begin bad++; $display("FAIL rand_addr: got %0d want %0d", rom_addr, m_addr); end
      if (chk) begin
        total++;
        if (pix_on !== ep || active_out !== ea) begin
          bad++; $display("FAIL rand_pix: got pix=%b act=%b want pix=%b act=%b", pix_on, active_out, ep, ea);
        end
      end
    end
  endtask

  task automatic test_async_reset();
    bit chk, ep, ea;
    for (int i = 0; i < 5; i++) begin
      drive(64, 200, 1'b1, i == 0, 24'h111111, chk, ep, ea);
      if (chk) begin
        total++;
        if (pix_on !== ep || active_out !== ea) begin
          bad++; $display("FAIL arst_pre: got pix=%b act=%b want pix=%b act=%b", pix_on, active_out, ep, ea);
        end
      end
    end
    total++; if (pix_on !== 1'b1) begin bad++; $display("FAIL arst_lit: got %b want 1", pix_on); end
    #3;
    reset_n = 1'b0;
    #1;
    total++; if (pix_on !== 1'b0) begin bad++; $display("FAIL arst_pix: got %b want 0", pix_on); end
    total++; if (active_out !== 1'b0) begin bad++; $display("FAIL arst_act: got %b want 0", active_out); end
    total++; if (rom_addr !== 6'd0) begin bad++; $display("FAIL arst_addr: got %0d want 0", rom_addr); end
    do_reset();
    for (int i = 0; i < 5; i++) begin
      drive(64, 200, 1'b1, i == 0, 24'h111111, chk, ep, ea);
      if (chk) begin
        total++;
        if (pix_on !== ep || active_out !== ea) begin
          bad++; $display("FAIL arst_post: got pix=%b act=%b want pix=%b act=%b", pix_on, active_out, ep, ea);
        end
      end
      if (i == 2) begin
        total++; if (pix_on !== 1'b1) begin bad++; $display("FAIL arst_recover: got %b want 1", pix_on); end
      end
    end
  endtask

  initial begin
    for (int i = 0; i < 64; i++) font[i] = (i < 50) ? 3'($urandom_range(0, 7)) : 3'b000;
    font[5] = 3'b101;
    reset_n = 1'b0;
    x = '0; y = '0; active = 1'b0; frame_start = 1'b0; digits = '0;
    lat = {6{BLANK_DIGIT}};
    m_addr = 0;
    test_reset();
    test_addr_map();
    test_latency();
    test_off_glyph();
    test_latch();
    test_random();
    test_async_reset();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
